// File: rtl/regfile_pkg.sv
// Shared register-file definitions: sweep FSM state encoding and the
// write-forwarding priority pick, reused by the integer and FP files.
package regfile_pkg;

  typedef enum logic {
    eRF_INIT,
    eRF_READY
  } regfile_state_e;

  // Widest write-port count any regfile instance supports.
  localparam int unsigned max_ws_lp = 4;

  // Index of the highest-numbered matching write port; the highest port
  // wins when several write the same address in one cycle.
  function automatic logic [1:0] regfile_fwd_pick(input logic [max_ws_lp-1:0] match_i);
    logic [1:0] sel;
    sel = '0;
    for (int unsigned k = 0; k < max_ws_lp; k++) begin
      if (match_i[k]) sel = 2'(k);
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port with write-first forwarding.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   ready_i          : file has completed its init sweep
//   r_v_i, r_addr_i  : read enable / address
//   entry_i          : array value at r_addr_i (0 when out of range)
//   w_ok_i           : per-write-port "write will be committed" qualifiers
//   w_addr_i, w_data_i : flattened write addresses / data
//   r_data_o         : registered read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int num_ws_p          = 1,
  parameter bit x0_tied_to_zero_p = 1'b1,
  parameter int addr_width_lp     = 5
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              ready_i,
  input  logic                              r_v_i,
  input  logic [addr_width_lp-1:0]          r_addr_i,
  input  logic [width_p-1:0]                entry_i,
  input  logic [num_ws_p-1:0]               w_ok_i,
  input  logic [num_ws_p*addr_width_lp-1:0] w_addr_i,
  input  logic [num_ws_p*width_p-1:0]       w_data_i,
  output logic [width_p-1:0]                r_data_o
);

  logic [max_ws_lp-1:0] match;
  logic [1:0]           pick;
  logic [width_p-1:0]   fwd_data;
  logic [width_p-1:0]   rd_next;

  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < num_ws_p; k++) begin
      match[k] = w_ok_i[k] && (w_addr_i[k*addr_width_lp +: addr_width_lp] == r_addr_i);
    end
  end

  assign pick = regfile_fwd_pick(match);

  always_comb begin
    fwd_data = '0;
    for (int unsigned k = 0; k < num_ws_p; k++) begin
      if (pick == 2'(k)) fwd_data = w_data_i[k*width_p +: width_p];
    end
  end

  always_comb begin
    if ((int'(r_addr_i) >= els_p) || (x0_tied_to_zero_p && (r_addr_i == '0)))
      rd_next = '0;
    else if (|match)
      rd_next = fwd_data;
    else
      rd_next = entry_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      r_data_o <= '0;
    else if (ready_i && r_v_i)
      r_data_o <= rd_next;
  end

endmodule

// File: rtl/regfile_nrnw_sync.sv
// N-read / M-write register file, synchronous reads with write-first
// forwarding, self-initialising via a post-reset sweep.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   ready_o          : high once every entry holds init_val_p
//   r_v_i/r_addr_i   : per-read-port enable / address (flattened)
//   r_data_o         : per-read-port registered data (flattened)
//   w_v_i/w_addr_i/w_data_i : per-write-port enable / address / data
module regfile_nrnw_sync
  import regfile_pkg::*;
#(
  parameter int                   width_p           = 32,
  parameter int                   els_p             = 32,
  parameter int                   num_rs_p          = 2,
  parameter int                   num_ws_p          = 1,
  parameter bit                   x0_tied_to_zero_p = 1'b1,
  parameter logic [width_p-1:0]   init_val_p        = '0,
  localparam int                  addr_width_lp     = $clog2(els_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  output logic                              ready_o,
  input  logic [num_rs_p-1:0]               r_v_i,
  input  logic [num_rs_p*addr_width_lp-1:0] r_addr_i,
  output logic [num_rs_p*width_p-1:0]       r_data_o,
  input  logic [num_ws_p-1:0]               w_v_i,
  input  logic [num_ws_p*addr_width_lp-1:0] w_addr_i,
  input  logic [num_ws_p*width_p-1:0]       w_data_i
);

  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  regfile_state_e           state_q;
  logic [addr_width_lp-1:0] sweep_q;
  logic [width_p-1:0]       mem_q [els_p];
  logic [num_ws_p-1:0]      w_ok;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eRF_INIT;
      sweep_q <= '0;
    end else begin
      case (state_q)
        eRF_INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == last_addr_lp) state_q <= eRF_READY;
        end
        default: state_q <= eRF_READY;
      endcase
    end
  end

  assign ready_o = (state_q == eRF_READY);

  // A write commits only when ready, in range, and not to a tied x0.
  always_comb begin
    w_ok = '0;
    for (int unsigned k = 0; k < num_ws_p; k++) begin
      w_ok[k] = ready_o && w_v_i[k]
             && (int'(w_addr_i[k*addr_width_lp +: addr_width_lp]) < els_p)
             && !(x0_tied_to_zero_p && (w_addr_i[k*addr_width_lp +: addr_width_lp] == '0));
    end
  end

  // Ascending port order lets the highest-index port win on collisions.
  always_ff @(posedge clk_i) begin
    if (state_q == eRF_INIT) begin
      mem_q[sweep_q] <= init_val_p;
    end else begin
      for (int unsigned k = 0; k < num_ws_p; k++) begin
        if (w_ok[k]) mem_q[w_addr_i[k*addr_width_lp +: addr_width_lp]] <= w_data_i[k*width_p +: width_p];
      end
    end
  end

  for (genvar j = 0; j < num_rs_p; j++) begin : g_rd
    logic [addr_width_lp-1:0] addr;
    logic [width_p-1:0]       entry_val;

    assign addr = r_addr_i[j*addr_width_lp +: addr_width_lp];

    always_comb begin
      entry_val = '0;
      if (int'(addr) < els_p) entry_val = mem_q[addr];
    end

    regfile_read_port #(
      .width_p          (width_p),
      .els_p            (els_p),
      .num_ws_p         (num_ws_p),
      .x0_tied_to_zero_p(x0_tied_to_zero_p),
      .addr_width_lp    (addr_width_lp)
    ) u_rd (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .ready_i  (ready_o),
      .r_v_i    (r_v_i[j]),
      .r_addr_i (addr),
      .entry_i  (entry_val),
      .w_ok_i   (w_ok),
      .w_addr_i (w_addr_i),
      .w_data_i (w_data_i),
      .r_data_o (r_data_o[j*width_p +: width_p])
    );
  end

endmodule

// File: tb/tb_regfile_nrnw_sync.sv
module tb_regfile_nrnw_sync;

  localparam logic [31:0] INIT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  r_v;
  logic [9:0]  r_addr;
  logic [1:0]  w_v;
  logic [9:0]  w_addr;
  logic [63:0] w_data;
  logic        ready_a, ready_b;
  logic [63:0] rdata_a, rdata_b;

  int total = 0;
  int bad   = 0;

  // Reference model: instance 0 = els 24 / x0 tied, instance 1 = els 32 / x0 free.
  int          els  [2] = '{24, 32};
  bit          x0   [2] = '{1'b1, 1'b0};
  int          cnt  [2];
  logic [31:0] mm   [2][32];
  logic [31:0] mr   [2][2];

  always #5 clk = ~clk;

  regfile_nrnw_sync #(
    .width_p(32), .els_p(24), .num_rs_p(2), .num_ws_p(2),
    .x0_tied_to_zero_p(1'b1), .init_val_p(INIT)
  ) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .ready_o(ready_a),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rdata_a),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data)
  );

  regfile_nrnw_sync #(
    .width_p(32), .els_p(32), .num_rs_p(2), .num_ws_p(2),
    .x0_tied_to_zero_p(1'b0), .init_val_p(INIT)
  ) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .ready_o(ready_b),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rdata_b),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("ready_a", {31'd0, ready_a}, {31'd0, cnt[0] >= els[0]});
    chk("ready_b", {31'd0, ready_b}, {31'd0, cnt[1] >= els[1]});
    chk("rdata_a0", rdata_a[31:0],  mr[0][0]);
    chk("rdata_a1", rdata_a[63:32], mr[0][1]);
    chk("rdata_b0", rdata_b[31:0],  mr[1][0]);
    chk("rdata_b1", rdata_b[63:32], mr[1][1]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0;
      mr[i][0] = '0;
      mr[i][1] = '0;
    end
  endtask

  // One clock edge: update the model from the inputs present at the edge,
  // then compare just after it.
  task automatic step();
    int wa, ra;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (cnt[i] >= els[i]) begin
        for (int k = 0; k < 2; k++) begin
          wa = int'(w_addr[k*5 +: 5]);
          if (w_v[k] && wa < els[i] && !(x0[i] && wa == 0)) mm[i][wa] = w_data[k*32 +: 32];
        end
        // Reads see the post-write contents: write-first semantics.
        for (int j = 0; j < 2; j++) begin
          ra = int'(r_addr[j*5 +: 5]);
          if (r_v[j]) mr[i][j] = (ra >= els[i] || (x0[i] && ra == 0)) ? 32'd0 : mm[i][ra];
        end
      end else begin
        cnt[i]++;
        if (cnt[i] == els[i]) for (int e = 0; e < 32; e++) mm[i][e] = INIT;
      end
    end
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic set_w(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
    w_v[k] = v;
    w_addr[k*5 +: 5] = a;
    w_data[k*32 +: 32] = d;
  endtask

  task automatic set_r(input int j, input logic v, input logic [4:0] a);
    r_v[j] = v;
    r_addr[j*5 +: 5] = a;
  endtask

  function automatic logic [4:0] rand_addr();
    logic [4:0] hot [6] = '{5'd0, 5'd5, 5'd7, 5'd23, 5'd24, 5'd30};
    if ($urandom_range(0, 1) == 0) return hot[$urandom_range(0, 5)];
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_inputs(input bit allow_w);
    for (int k = 0; k < 2; k++) set_w(k, allow_w && ($urandom_range(0, 2) != 0), rand_addr(), $urandom());
    for (int j = 0; j < 2; j++) set_r(j, $urandom_range(0, 2) != 0, rand_addr());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    r_v = '0; r_addr = '0; w_v = '0; w_addr = '0; w_data = '0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Partial sweep with traffic that must be ignored, then reset mid-sweep.
    for (int n = 0; n < 10; n++) begin
      rand_inputs(1'b1);
      step();
    end
    pulse_reset();

    // Full sweep; traffic continues while either file is still initialising.
    for (int n = 0; n < 34; n++) begin
      rand_inputs(n < 20);
      step();
    end
    w_v = '0;

    // Every entry of both files after the sweep.
    for (int n = 0; n < 16; n++) begin
      set_r(0, 1'b1, 5'(2*n));
      set_r(1, 1'b1, 5'(2*n + 1));
      step();
    end
    r_v = '0;

    // Basic write then read, then hold.
    set_w(0, 1'b1, 5'd5, 32'h1234_5678);
    step();
    w_v = '0;
    set_r(0, 1'b1, 5'd5);
    step();
    r_v = '0;
    for (int n = 0; n < 3; n++) step();

    // Same-address write collision with concurrent read, then re-read.
    set_w(0, 1'b1, 5'd7, 32'h0000_000A);
    set_w(1, 1'b1, 5'd7, 32'h0000_000B);
    set_r(1, 1'b1, 5'd7);
    step();
    w_v = '0; r_v = '0;
    set_r(0, 1'b1, 5'd7);
    step();
    r_v = '0;

    // Entry 0 write / read on both ports.
    set_w(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    w_v = '0;
    set_r(0, 1'b1, 5'd0);
    set_r(1, 1'b1, 5'd0);
    step();
    r_v = '0;

    // Address 30: out of range for the 24-entry file.
    set_w(1, 1'b1, 5'd30, 32'h5555_AAAA);
    step();
    w_v = '0;
    set_r(0, 1'b1, 5'd30);
    set_r(1, 1'b1, 5'd30);
    step();

    for (int n = 0; n < 400; n++) begin
      rand_inputs(1'b1);
      step();
    end

    // Reset while ready, then a full sweep again and a few random cycles.
    pulse_reset();
    for (int n = 0; n < 34; n++) begin
      rand_inputs(1'b1);
      step();
    end
    for (int n = 0; n < 40; n++) begin
      rand_inputs(1'b1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_nrnw_sync.md
# regfile_nrnw_sync

Parametrised N-read/M-write register file for the vanilla core's integer and FP operand stages. Reads are synchronous with write-first forwarding. A built-in reset sweep initialises every entry to a known value instead of relying on simulation-only initialisation. It replaces the asynchronous-read 2R1W file wherever the core needs more ports, registered read data, or deterministic post-reset contents.

## Interface
- width_p, 32, data width of each entry
- els_p, 32, number of entries; must be ≥ 2; need not be a power of two
- num_rs_p, 2, number of read ports
- num_ws_p, 1, number of write ports; 1..4
- x0_tied_to_zero_p, 1, when 1, entry 0 reads as 0 and ignores writes
- init_val_p, 0, value written to every entry by the reset sweep
- addr_width_lp, $clog2(els_p), local parameter, not overridable

- clk_i  in  1  sole clock; all state updates on its rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- ready_o  out  1  high once the init sweep is complete; reads and writes are honoured only while high
- r_v_i  in  num_rs_p  per-port read enable
- r_addr_i  in  num_rs_p x addr_width_lp  per-port read address
- r_data_o  out  num_rs_p x width_p  per-port registered read data
- w_v_i  in  num_ws_p  per-port write enable
- w_addr_i  in  num_ws_p x addr_width_lp  per-port write address
- w_data_i  in  num_ws_p x width_p  per-port write data

## Operation
- FSM states are INIT and READY.
  - reset_n_i low forces INIT immediately, regardless of clock.
  - In INIT, a sweep counter starting at 0 writes init_val_p to entry[counter] on each edge, then increments.
  - After entry els_p-1 is written, the FSM moves to READY.
  - READY is held until the next reset.
- In INIT, all r_v_i and w_v_i are ignored. r_data_o holds its reset value.
- Writes (READY only): entry[w_addr_i[k]] <= w_data_i[k] for each k with w_v_i[k].
  - When several ports target the same address in one cycle, the highest-index port wins.
  - A write with address ≥ els_p is dropped.
  - When x0_tied_to_zero_p is set, a write to address 0 is dropped.
- Reads (READY only): on an edge with r_v_i[j], r_data_o[j] loads the entry value.
  - If any write port targets the same address in that cycle, r_data_o[j] loads the winning write data instead (write-first forwarding).
  - Address 0 with x0_tied_to_zero_p set loads 0. Address ≥ els_p loads 0.
  - With r_v_i[j] low, r_data_o[j] holds its previous value.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.

## Timing
- Reset values: ready_o = 0, every r_data_o = 0, FSM = INIT, sweep counter = 0. Array contents are undefined until the sweep completes.
- Sweep length: ready_o rises on the els_p-th rising edge after reset_n_i deasserts. It is high in the cycle after that edge.
- Read latency is 1 cycle: address presented in cycle N, data on r_data_o in cycle N+1, held until the next enabled read on that port.
- A write in cycle N is visible to a read issued in cycle N (forwarded) and to any later read.
- Reset asserted mid-sweep or mid-operation:
  - The sweep restarts from entry 0.
  - In-flight reads are lost; r_data_o returns to 0.
  - A write whose edge coincides with reset assertion is not guaranteed.

## Structure
- Shared package regfile_pkg holds the state enum regfile_state_e {eRF_INIT, eRF_READY}. The forwarding priority function is also a package function, reused by the FP regfile.
- Sub-module regfile_read_port, instantiated num_rs_p times. It contains the address compare against all write ports, the priority pick, the x0/out-of-range zeroing, and the output register.
- The array is a plain flop array. No SRAM macro is used at these sizes.

## Test plan
- Reset sweep: release reset with els_p=32. Required: ready_o low for 32 edges, high after the 32nd. Every entry then reads init_val_p; set init_val_p = 32'hDEAD_BEEF and check every entry.
- Basic read/write: write 32'h1234_5678 to entry 5 in cycle N; read entry 5 in cycle N+1. Required: r_data_o = 32'h1234_5678 in N+2, held while r_v_i stays low.
- Forwarding and priority: with num_ws_p=2, in one cycle port0 writes entry 7 = 32'hA and port1 writes entry 7 = 32'hB, while read port 1 reads entry 7. Required: read returns 32'hB next cycle, and a later read of entry 7 also returns 32'hB.
- x0 behaviour: write 32'hFFFF_FFFF to entry 0 with x0_tied_to_zero_p=1. Required: all read ports return 0. With x0_tied_to_zero_p=0, the reads return 32'hFFFF_FFFF.
- Gating and out-of-range: with els_p=24, issue reads and writes during INIT. Required: no array change and r_data_o stays 0. In READY, write address 30 then read address 30. Required: the write is dropped and the read returns 0.
- Reset mid-operation: assert reset_n_i low for 1 cycle midway through the sweep and again in READY. Required: r_data_o = 0 and ready_o = 0 immediately. The full els_p-edge sweep is then repeated from entry 0.
